// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module  : md_pkg
// Purpose : Shared types and constants for the RV32M multiply/divide unit.
//           md_op_e mirrors the RV32M funct3 encoding so the issued
//           instruction bits can be cast straight to an operation.
// Rev     : 1.0  initial release
// ============================================================================
package md_pkg;

  // funct3 encodings of the RV32M extension
  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  localparam int MD_ITERS = 32;

  // funct3[2] separates the divide family from the multiply family
  function automatic logic md_is_div(input md_op_e op);
    return op[2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_divider.sv
`default_nettype none
// ============================================================================
// Module  : md_divider
// Purpose : Unsigned radix-2 restoring divider datapath, one quotient bit
//           per enabled step. The outputs are the quotient/remainder as they
//           will be after the current step, so the controller can register
//           the final result on the same edge as the last iteration.
// Ports   : clk, rst        - clock, synchronous active-high clear
//           i_load          - capture dividend/divisor, clear remainder
//           i_step          - perform one restoring iteration
//           i_dividend      - unsigned dividend (magnitude)
//           i_divisor       - unsigned divisor (magnitude, non-zero)
//           o_quot_nxt      - quotient after the current step
//           o_rem_nxt       - remainder after the current step
// Rev     : 1.0  initial release
// ============================================================================
module md_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_step,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_quot_nxt,
  output logic [31:0] o_rem_nxt
);

  // r_quot starts as the dividend; its MSB feeds the partial remainder
  // each step while the new quotient bit enters at the LSB.
  logic [31:0] r_quot;
  logic [31:0] r_rem;
  logic [31:0] r_divisor;

  logic [32:0] w_shift;
  logic        w_ge;

  always_comb begin
    w_shift    = {r_rem, r_quot[31]};
    w_ge       = (w_shift >= {1'b0, r_divisor});
    // r_rem < divisor holds throughout, so the restored value fits 32 bits
    o_rem_nxt  = w_ge ? 32'(w_shift - {1'b0, r_divisor}) : w_shift[31:0];
    o_quot_nxt = {r_quot[30:0], w_ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
    end else if (i_load) begin
      r_quot    <= i_dividend;
      r_rem     <= '0;
      r_divisor <= i_divisor;
    end else if (i_step) begin
      r_quot    <= o_quot_nxt;
      r_rem     <= o_rem_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_div_fu.sv
`default_nettype none
// ============================================================================
// Module  : mult_div_fu
// Purpose : Iterative RV32M multiply/divide functional unit. Accepts one
//           issued op from the mult/div reservation station, computes it on
//           operand magnitudes and fixes the sign in the final step, then
//           broadcasts the result on its CDB lane with the ROB tag.
// Config  : MULT_DIV_FAST_MUL_EN - when defined, multiplies use a single
//           33x33 signed multiply registered in BUSY instead of the
//           32-iteration shift-add path. Division is unaffected.
// Ports   : clk, rst, flush  - clock, sync active-high reset, squash
//           issue_valid      - station issue, held until after resp
//           instr_in         - instruction (funct3 only)
//           tag_dest_in      - destination ROB tag
//           data_A_in/B_in   - rs1 / rs2 values
//           resp             - completion pulse back to the station
//           cdb_valid/tag/data - CDB broadcast lane
// Rev     : 1.0  initial release
// ============================================================================
module mult_div_fu #(
  parameter int ROB_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         issue_valid,
  input  logic [31:0]                  instr_in,
  input  logic [$clog2(ROB_DEPTH)-1:0] tag_dest_in,
  input  logic [31:0]                  data_A_in,
  input  logic [31:0]                  data_B_in,
  output logic                         resp,
  output logic                         cdb_valid,
  output logic [$clog2(ROB_DEPTH)-1:0] cdb_tag,
  output logic [31:0]                  cdb_data
);
  import md_pkg::*;

  md_state_e                    r_state;
  md_op_e                       r_op;
  logic [$clog2(ROB_DEPTH)-1:0] r_tag;
  logic [5:0]                   r_cnt;
  logic                         r_neg;
  logic                         r_special;
  logic [31:0]                  r_cdb_data;

  // ---------------- operand preparation at acceptance -----------------------
  md_op_e      w_op_in;
  logic        w_sa, w_sb, w_neg_in;
  logic [31:0] w_mag_a, w_mag_b;
  logic        w_div0, w_ovf;
  logic [31:0] w_spec_res;
  logic        w_accept;

  always_comb begin
    w_op_in  = md_op_e'(instr_in[14:12]);
    w_sa     = data_A_in[31] & (w_op_in == MULH || w_op_in == MULHSU ||
                                w_op_in == DIV  || w_op_in == REM);
    w_sb     = data_B_in[31] & (w_op_in == MULH || w_op_in == DIV ||
                                w_op_in == REM);
    w_mag_a  = w_sa ? (~data_A_in + 32'd1) : data_A_in;
    w_mag_b  = w_sb ? (~data_B_in + 32'd1) : data_B_in;
    // remainder follows the dividend's sign; everything else the XOR
    w_neg_in = (w_op_in == REM) ? w_sa : (w_sa ^ w_sb);

    w_div0   = md_is_div(w_op_in) && (data_B_in == 32'd0);
    w_ovf    = (w_op_in == DIV || w_op_in == REM) &&
               (data_A_in == 32'h8000_0000) && (data_B_in == 32'hFFFF_FFFF);
    if (w_div0)
      w_spec_res = instr_in[13] ? data_A_in : 32'hFFFF_FFFF;
    else if (w_ovf)
      w_spec_res = instr_in[13] ? 32'd0 : 32'h8000_0000;
    else
      w_spec_res = 32'd0;

    w_accept = (r_state == IDLE) && issue_valid;
  end

  logic w_last;
  assign w_last = (r_cnt == 6'(MD_ITERS - 1));

  // ---------------- divider ----------------------------------------------
  logic        w_div_clr;
  logic        w_div_step;
  logic [31:0] w_quot_nxt, w_rem_nxt;
  logic [31:0] w_div_sel, w_div_res;

  assign w_div_clr  = rst | flush;
  assign w_div_step = (r_state == BUSY) && !r_special && md_is_div(r_op);

  md_divider u_divider (
    .clk        (clk),
    .rst        (w_div_clr),
    .i_load     (w_accept),
    .i_step     (w_div_step),
    .i_dividend (w_mag_a),
    .i_divisor  (w_mag_b),
    .o_quot_nxt (w_quot_nxt),
    .o_rem_nxt  (w_rem_nxt)
  );

  always_comb begin
    w_div_sel = r_op[1] ? w_rem_nxt : w_quot_nxt;
    w_div_res = r_neg ? (~w_div_sel + 32'd1) : w_div_sel;
  end

  // ---------------- multiplier -------------------------------------------
`ifdef MULT_DIV_FAST_MUL_EN
  logic [31:0]        r_raw_a, r_raw_b;
  logic signed [32:0] w_fa, w_fb;
  logic signed [65:0] w_fast_prod;
  logic [31:0]        w_mul_res;

  always_comb begin
    // sign-extend only the operands the op treats as signed
    w_fa        = {(r_op == MULH || r_op == MULHSU) & r_raw_a[31], r_raw_a};
    w_fb        = {(r_op == MULH) & r_raw_b[31], r_raw_b};
    w_fast_prod = 66'(w_fa) * 66'(w_fb);
    w_mul_res   = (r_op == MUL) ? w_fast_prod[31:0] : w_fast_prod[63:32];
  end

  logic w_unused;
  assign w_unused = &{1'b0, instr_in[31:15], instr_in[11:0], w_fast_prod[65:64]};
`else
  // r_prod holds {partial sum, remaining multiplier bits}; each step adds
  // the multiplicand into the upper half on the LSB and shifts right.
  logic [31:0] r_mcand;
  logic [63:0] r_prod;
  logic [32:0] w_sum;
  logic [63:0] w_prod_nxt, w_prod_fin;
  logic [31:0] w_mul_res;

  always_comb begin
    w_sum      = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_mcand} : 33'd0);
    w_prod_nxt = {w_sum, r_prod[31:1]};
    w_prod_fin = r_neg ? (~w_prod_nxt + 64'd1) : w_prod_nxt;
    w_mul_res  = (r_op == MUL) ? w_prod_fin[31:0] : w_prod_fin[63:32];
  end

  logic w_unused;
  assign w_unused = &{1'b0, instr_in[31:15], instr_in[11:0]};
`endif

  // ---------------- control FSM ------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state    <= IDLE;
      r_op       <= MUL;
      r_tag      <= '0;
      r_cnt      <= '0;
      r_neg      <= 1'b0;
      r_special  <= 1'b0;
      r_cdb_data <= '0;
`ifdef MULT_DIV_FAST_MUL_EN
      r_raw_a    <= '0;
      r_raw_b    <= '0;
`else
      r_mcand    <= '0;
      r_prod     <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (issue_valid) begin
            r_state    <= BUSY;
            r_op       <= w_op_in;
            r_tag      <= tag_dest_in;
            r_cnt      <= '0;
            r_neg      <= w_neg_in;
            r_special  <= w_div0 | w_ovf;
            // special-case result is known now; BUSY just waits one cycle
            r_cdb_data <= w_spec_res;
`ifdef MULT_DIV_FAST_MUL_EN
            r_raw_a    <= data_A_in;
            r_raw_b    <= data_B_in;
`else
            r_mcand    <= w_mag_a;
            r_prod     <= {32'd0, w_mag_b};
`endif
          end
        end
        BUSY: begin
          if (r_special) begin
            r_state <= DONE;
          end else if (!md_is_div(r_op)) begin
`ifdef MULT_DIV_FAST_MUL_EN
            r_cdb_data <= w_mul_res;
            r_state    <= DONE;
`else
            r_prod <= w_prod_nxt;
            r_cnt  <= r_cnt + 6'd1;
            if (w_last) begin
              r_cdb_data <= w_mul_res;
              r_state    <= DONE;
            end
`endif
          end else begin
            r_cnt <= r_cnt + 6'd1;
            if (w_last) begin
              r_cdb_data <= w_div_res;
              r_state    <= DONE;
            end
          end
        end
        // the station still holds issue_valid here, so it is ignored
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign resp      = (r_state == DONE) && !flush;
  assign cdb_valid = (r_state == DONE) && !flush;
  assign cdb_tag   = r_tag;
  assign cdb_data  = r_cdb_data;

endmodule
`default_nettype wire

// File: doc/mult_div_fu.md
# mult_div_fu

Iterative RV32M multiply/divide functional unit. It sits directly downstream of the mult/div reservation station. It accepts one issued instruction with both source operands resolved, computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, and broadcasts the result on its CDB lane with the destination ROB tag. It returns `resp` to the reservation station so the station can free the entry.

## Interface
Parameters:
- `ROB_DEPTH`, default 4, ROB entries; tag width is `$clog2(ROB_DEPTH)`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: squash any in-flight op; synchronous, same effect as `rst`.
- `issue_valid` in 1: reservation station `comp_issue`. Held high with stable operands until the cycle after `resp`.
- `instr_in` in 32: issued instruction; only funct3 = `instr_in[14:12]` is used.
- `tag_dest_in` in `$clog2(ROB_DEPTH)`: destination ROB tag.
- `data_A_in` in 32: rs1 value.
- `data_B_in` in 32: rs2 value.
- `resp` out 1: one-cycle pulse; operation complete.
- `cdb_valid` out 1: CDB lane valid, same cycle as `resp`.
- `cdb_tag` out `$clog2(ROB_DEPTH)`: latched destination tag.
- `cdb_data` out 32: result.

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY when `issue_valid`. At that edge, latch funct3, tag, operand magnitudes and sign flags, and clear the iteration counter (6 bits).
  - BUSY: one iteration per cycle. BUSY → DONE after the final iteration.
  - DONE → IDLE unconditionally. `issue_valid` is ignored in DONE because the station still holds it high that cycle.
- Sign handling:
  - MULH and DIV/REM take |A| and |B|.
  - MULHSU takes |A| with B unsigned.
  - The U variants are unsigned throughout.
  - The result is negated in the final step when the sign flags differ. REM takes the sign of the dividend.
- Multiply: radix-2 shift-add on a 64-bit accumulator, 32 iterations. MUL returns product[31:0]; MULH* return product[63:32].
- Divide: radix-2 restoring, 32 iterations, producing a 32-bit quotient and remainder.
- Special cases are short-circuited with exactly 1 BUSY cycle:
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- `resp`, `cdb_valid` = (state==DONE) & ~`flush`. `cdb_data` and `cdb_tag` come from registers.

## Timing
- Reset/flush values: state IDLE; `resp`, `cdb_valid`, `cdb_tag`, `cdb_data`, counter and accumulators all 0.
- Let the accepting edge be cycle 0.
  - Iterative ops: BUSY for cycles 1–32, `resp` in cycle 33.
  - Short-circuit ops: `resp` in cycle 2.
- Earliest next acceptance is the cycle after DONE, and only if `issue_valid` is high again (a new station entry).
- `flush` asserted in any cycle returns the FSM to IDLE at the next edge. No `resp` or `cdb_valid` is produced for the squashed op. If `flush` coincides with DONE, the outputs are suppressed that cycle.
- `rst` has priority over all other inputs.

## Configuration
- `MULT_DIV_FAST_MUL_EN`
  - Defined: multiply ops use a single-cycle 33×33 signed multiply registered in BUSY, so `resp` arrives in cycle 2.
  - Undefined: the 32-iteration shift-add path is used, with `resp` in cycle 33.
- Division is unaffected by this macro.

## Structure
- `md_pkg` holds:
  - the `md_op_e` enum of the funct3 encodings (MUL=0 … REMU=7);
  - the `md_state_e` enum (IDLE/BUSY/DONE);
  - the constant `MD_ITERS`=32.
- Sub-module `md_divider`: unsigned restoring divider datapath (step-enable in, quotient/remainder out). The top level owns the FSM, sign handling, special cases and the multiplier.

## Test plan
- MUL 7 × 0xFFFFFFFD → `cdb_data`=0xFFFFFFEB, `resp` and `cdb_valid` in cycle 33 (cycle 2 with FAST_MUL), `cdb_tag`=`tag_dest_in`.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM of the same → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2; `resp` in cycle 33.
- DIVU 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0. All with `resp` in cycle 2.
- `flush` at cycle 10 of a DIV → no `resp` or `cdb_valid` ever for it. An issue presented the cycle after the flush is accepted and completes normally.
- Back-to-back: `issue_valid` held high through DONE → exactly one `resp` per op. The second op is accepted the cycle after DONE and returns its own tag.
